// File: rtl/ipv4_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the IPv4 TX datapath between REQ_N transport requesters.
// Optional stall timeout in LOCK is compiled in when IPV4_TX_ARB_TIMEOUT_EN is defined.

module ipv4_tx_arbiter #(
  parameter int REQ_N   = 2,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = $clog2(DATA_W/8+1),
  parameter int PROT_W  = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ_N-1:0]          req_i,
  output logic [REQ_N-1:0]          grant_o,
  output logic [REQ_N-1:0]          ready_o,
  input  logic [REQ_N-1:0]          valid_i,
  input  logic [REQ_N-1:0]          start_i,
  input  logic [REQ_N-1:0]          term_i,
  input  logic [REQ_N*DATA_W-1:0]   data_i,
  input  logic [REQ_N*LEN_W-1:0]    len_i,
  input  logic [REQ_N*PROT_W-1:0]   prot_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic                      start_o,
  output logic                      term_o,
  output logic [DATA_W-1:0]         data_o,
  output logic [LEN_W-1:0]          len_o,
  output logic [PROT_W-1:0]         prot_o,
  output logic                      cancel_o
);

  // state | meaning
  // IDLE  | no grant; pick first pending req_i scanning up from the rr pointer
  // LOCK  | grant held on one requester until its term beat is accepted or it aborts
  // GAP   | forced idle of GAP_CYC cycles after a packet end or abort

  localparam int PTR_W    = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  if (REQ_N < 2 || REQ_N > 8 || DATA_W != 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("ipv4_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [REQ_N-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PROT_W-1:0]  prot_q, prot_d;
  logic               cancel_q, cancel_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [PTR_W-1:0]   win_idx, gnt_idx, nxt_ptr;
  logic               win_found;
  logic               xfer, pkt_end, pkt_abort, timeout_hit;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < REQ_N; k++) begin
      if (!win_found && req_i[(int'(ptr_q) + k) % REQ_N]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + k) % REQ_N);
      end
    end
  end

  // grant_q is one-hot or zero, so this reduces to a plain AND-OR mux
  always_comb begin
    start_o = 1'b0;
    term_o  = 1'b0;
    data_o  = '0;
    len_o   = '0;
    gnt_idx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (grant_q[i]) begin
        start_o = start_i[i];
        term_o  = term_i[i];
        data_o  = data_i[i*DATA_W +: DATA_W];
        len_o   = len_i[i*LEN_W +: LEN_W];
        gnt_idx = PTR_W'(i);
      end
    end
  end

  assign valid_o  = |(grant_q & valid_i);
  assign ready_o  = grant_q & {REQ_N{ready_i}};
  assign grant_o  = grant_q;
  assign prot_o   = prot_q;
  assign cancel_o = cancel_q;

  assign xfer      = valid_o & ready_i;
  assign pkt_end   = xfer & term_o;
  assign pkt_abort = ~pkt_end & (~req_i[gnt_idx] | timeout_hit);
  assign nxt_ptr   = (gnt_idx == PTR_W'(REQ_N-1)) ? '0 : gnt_idx + PTR_W'(1);

`ifdef IPV4_TX_ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT+1);
  logic [ST_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_LOCK || xfer) stall_q <= '0;
    else                                     stall_q <= stall_q + ST_W'(1);
  end

  assign timeout_hit = (state_q == ST_LOCK) && !xfer && (stall_q == ST_W'(TIMEOUT-1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    prot_d   = prot_q;
    cancel_d = 1'b0;
    gap_d    = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          prot_d           = prot_i[int'(win_idx)*PROT_W +: PROT_W];
          state_d          = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (pkt_end || pkt_abort) begin
          cancel_d = pkt_abort;
          grant_d  = '0;
          ptr_d    = nxt_ptr;
          gap_d    = GAP_W'(GAP_LOAD);
          state_d  = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      prot_q   <= '0;
      cancel_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      prot_q   <= prot_d;
      cancel_q <= cancel_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: doc/ipv4_tx_arbiter.md
Name: ipv4_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the single IPv4 TX header/datapath between REQ_N transport-layer requesters (e.g. UDP, ICMP).
- Grants one requester at a time and holds the grant from start beat to term beat.
- Muxes the winner's stream and protocol number to the IPv4 TX block, and enforces an inter-packet gap.
- Sits between the transport TX blocks and the IPv4 TX block.

Parameters:
- REQ_N, 2, number of requesters (2..8).
- DATA_W, 16, stream data width; only 16 is supported.
- LEN_W, $clog2(DATA_W/8+1), byte-count width (derived).
- PROT_W, 8, IPv4 protocol field width.
- GAP_CYC, 2, idle cycles forced after each packet end/abort; 0 is allowed.
- TIMEOUT, 64, stall limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- req_i  in  REQ_N  requester i has a packet pending; held until its term beat is accepted
- grant_o  out  REQ_N  one-hot registered grant
- ready_o  out  REQ_N  per-requester accept; = grant_o[i] & ready_i
- valid_i  in  REQ_N  per-requester beat valid
- start_i  in  REQ_N  first beat of packet
- term_i  in  REQ_N  last beat of packet
- data_i  in  REQ_N*DATA_W  flattened data; requester i at [i*DATA_W+:DATA_W]
- len_i  in  REQ_N*LEN_W  flattened valid byte count per beat
- prot_i  in  REQ_N*PROT_W  flattened protocol number (e.g. 8'd17 for UDP)
- ready_i  in  1  downstream IPv4 TX accepts a beat
- valid_o, start_o, term_o  out  1  muxed stream controls
- data_o  out  DATA_W  muxed data
- len_o  out  LEN_W  muxed byte count
- prot_o  out  PROT_W  protocol latched at grant
- cancel_o  out  1  one-cycle abort pulse to downstream

Behaviour:
- Reset values: state IDLE, grant_o=0, rr pointer=0, prot_o=0, cancel_o=0, gap counter=0. valid_o/start_o/term_o=0 because grant_o=0.
- Reset mid-packet: grant dropped next cycle; no cancel_o is issued.
- FSM states: IDLE, LOCK, GAP.
- IDLE:
  - If |req_i, select the first set req bit scanning from the pointer upward, modulo REQ_N.
  - Next cycle: grant_o one-hot, prot_o = prot_i of the winner, state LOCK. Grant latency is 1 cycle after req seen.
  - No req: stay in IDLE.
- LOCK:
  - Outputs are a combinational mux by grant_o: valid_o=|(grant_o&valid_i); start/term/data/len come from the granted index.
  - A beat transfers when valid_o & ready_i.
  - Transfer with term_o: grant_o cleared next cycle, pointer = winner+1 (wraps REQ_N-1 to 0), state GAP (or IDLE if GAP_CYC=0).
  - Granted req_i deasserts before its term beat: abort. cancel_o=1 for the next cycle, grant cleared, pointer advances, state GAP.
  - Non-granted requesters see ready_o=0; their valid_i is ignored.
- GAP:
  - Counter counts GAP_CYC cycles, then IDLE.
  - req_i is sampled but not granted during GAP.
  - First grant after GAP appears at cycle GAP_CYC+2 after the last term transfer.
- start_i on a beat after the first is forwarded unmodified; the arbiter does not police framing.
- term beat with ready_i=0: grant is held until the term is accepted.
- Single requester, back-to-back packets: its packets are separated by GAP_CYC+1 idle cycles minimum.
- Fairness: each active requester is granted at most once per REQ_N grants while others request.

Optional Feature:
- Macro: IPV4_TX_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter in LOCK resets on every transfer and increments otherwise.
  - Reaching TIMEOUT (no transfer for TIMEOUT consecutive cycles): cancel_o pulses 1 cycle, grant cleared, pointer advances, state GAP.
  - This is independent of whether the stall comes from valid_i or ready_i.
- Undefined: no counter; LOCK may persist indefinitely; the TIMEOUT parameter is ignored.

Test Plan:
- REQ_N=2, only req_i=2'b01, 3-beat packet, ready_i=1, prot_i[0]=17 -> grant_o=01 one cycle later; prot_o=17; 3 valid_o beats with start on beat 1 and term on beat 3; grant_o=0 after term; 2 GAP cycles.
- req_i=2'b11 continuously, 2-beat packets -> grants alternate 01,10,01,10; pointer wraps 1->0.
- ready_i low 5 cycles mid-packet -> ready_o=0, data_o held stable, no grant change; packet resumes intact.
- Granted requester drops req_i after beat 1 of 4 -> cancel_o=1 for exactly 1 cycle, grant cleared, other requester granted after GAP.
- Reset asserted in LOCK mid-packet -> next cycle grant_o=0, cancel_o=0, state IDLE; re-arbitration starts at pointer 0.
- IPV4_TX_ARB_TIMEOUT_EN, TIMEOUT=8, granted valid_i held low -> cancel_o pulse on the 9th cycle; grant released.
